// File: rtl/calcu16_mem_pkg.sv
// Shared constants, requester IDs and arbiter state encoding for the Calcu-16 memory arbiter.
package calcu16_mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 26;

    localparam int REQ_FETCH  = 0;
    localparam int REQ_DATA   = 1;
    localparam int REQ_LOADER = 2;

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/calcu16_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first valid requester after ptr_i.
module calcu16_rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o
);

    logic             found_s;
    logic [PTR_W-1:0] idx_s;

    // scan ptr+1, ptr+2, ... modulo N and keep the first hit
    always_comb begin
        grant_o = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 1; k <= N; k++) begin
            idx_s = PTR_W'((int'(ptr_i) + k) % N);
            if (valid_i[idx_s] && !found_s) begin
                grant_o[idx_s] = 1'b1;
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/calcu16_mem_arbiter.sv
// Round-robin arbiter with bus lock for the unified Calcu-16 memory.
// Optional lock watchdog: define CALCU16_ARB_LOCK_TIMEOUT_EN (adds LOCK_TMO and lock_broken).
module calcu16_mem_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = calcu16_mem_pkg::ADDR_W,
    parameter int DATA_W  = calcu16_mem_pkg::DATA_W
`ifdef CALCU16_ARB_LOCK_TIMEOUT_EN
    ,
    parameter int LOCK_TMO = 16
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
`ifdef CALCU16_ARB_LOCK_TIMEOUT_EN
    output logic                        lock_broken,
`endif
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    import calcu16_mem_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e         state_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   owner_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic               rsp_rd_q;

    logic [NUM_REQ-1:0] owner_oh_s;
    logic [NUM_REQ-1:0] cand_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [PTR_W-1:0]   win_idx_s;
    logic               win_we_s;
    logic               win_lock_s;
    logic               grant_any_s;

`ifdef CALCU16_ARB_LOCK_TIMEOUT_EN
    logic [7:0]         idle_cnt_q;
    logic               lock_broken_q;
`endif

    // one-hot form of the lock owner, used to mask the picker while locked
    always_comb begin
        owner_oh_s          = '0;
        owner_oh_s[owner_q] = 1'b1;
    end

    // candidates: everyone while open, only the owner while locked, nobody in reset
    always_comb begin
        if (rst) begin
            cand_s = '0;
        end else if (state_q == LOCKED) begin
            cand_s = req_valid & owner_oh_s;
        end else begin
            cand_s = req_valid;
        end
    end

    calcu16_rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .valid_i (cand_s),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_s)
    );

    // AND-OR mux of the winner's request onto the memory port; all zero without a grant
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        win_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mem_addr  |= req_addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{grant_s[i]}};
            mem_wdata |= req_wdata[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}};
            win_idx_s |= PTR_W'(i) & {PTR_W{grant_s[i]}};
        end
    end

    assign grant_any_s = |grant_s;
    assign win_we_s    = |(grant_s & req_we);
    assign win_lock_s  = |(grant_s & req_lock);

    assign req_ready = grant_s;
    assign mem_en    = grant_any_s;
    assign mem_we    = win_we_s;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rd_q ? mem_rdata : '0;
`ifdef CALCU16_ARB_LOCK_TIMEOUT_EN
    assign lock_broken = lock_broken_q;
`endif

    // arbitration state, round-robin pointer, lock owner and response tag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= OPEN;
            owner_q     <= PTR_W'(REQ_FETCH);
            rr_ptr_q    <= PTR_W'(NUM_REQ - 1);
            rsp_valid_q <= '0;
            rsp_rd_q    <= 1'b0;
`ifdef CALCU16_ARB_LOCK_TIMEOUT_EN
            idle_cnt_q    <= 8'd0;
            lock_broken_q <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= grant_s;
            rsp_rd_q    <= grant_any_s & ~win_we_s;
`ifdef CALCU16_ARB_LOCK_TIMEOUT_EN
            lock_broken_q <= 1'b0;
`endif
            case (state_q)
                OPEN: begin
                    if (grant_any_s) begin
                        rr_ptr_q <= win_idx_s;
                        if (win_lock_s) begin
                            state_q <= LOCKED;
                            owner_q <= win_idx_s;
                        end
                    end
`ifdef CALCU16_ARB_LOCK_TIMEOUT_EN
                    idle_cnt_q <= 8'd0;
`endif
                end
                LOCKED: begin
                    // a missing grant here means the owner is idle
                    if (grant_any_s) begin
                        if (!win_lock_s) begin
                            state_q <= OPEN;
                        end
`ifdef CALCU16_ARB_LOCK_TIMEOUT_EN
                        idle_cnt_q <= 8'd0;
`endif
                    end
`ifdef CALCU16_ARB_LOCK_TIMEOUT_EN
                    else if (idle_cnt_q + 8'd1 == 8'(LOCK_TMO)) begin
                        state_q       <= OPEN;
                        idle_cnt_q    <= 8'd0;
                        lock_broken_q <= 1'b1;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 8'd1;
                    end
`endif
                end
                default: begin
                    state_q <= OPEN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calcu16_mem_arbiter.sv
// Directed self-checking bench for calcu16_mem_arbiter with a simple synchronous memory model.
module tb_calcu16_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_we;
    logic [2:0]  req_lock;
    logic [47:0] req_addr;
    logic [77:0] req_wdata;
    logic [2:0]  rsp_valid;
    logic [25:0] rsp_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [25:0] mem_wdata;
    logic [25:0] mem_rdata;
`ifdef CALCU16_ARB_LOCK_TIMEOUT_EN
    logic        lock_broken;
`endif

    int n_checks;
    int n_fail;

    logic [25:0] mem [0:65535];

    calcu16_mem_arbiter #(
        .NUM_REQ (3)
`ifdef CALCU16_ARB_LOCK_TIMEOUT_EN
        ,
        .LOCK_TMO (4)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
`ifdef CALCU16_ARB_LOCK_TIMEOUT_EN
        .lock_broken (lock_broken),
`endif
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: preloaded in reset, write at the grant edge, read data one cycle later
    always @(posedge clk) begin
        if (rst) begin
            mem[16'h0000] <= 26'h0000100;
            mem[16'h0001] <= 26'h0000101;
            mem[16'h0002] <= 26'h0000102;
            mem[16'h0010] <= 26'h00003AB;
            mem[16'h0040] <= 26'h0000000;
            mem_rdata     <= 26'h0;
        end else if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                           input logic [15:0] a, input logic [25:0] d);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_lock[i]           = lk;
        req_addr[i*16 +: 16]  = a;
        req_wdata[i*26 +: 26] = d;
    endtask

    task automatic idle_all();
        req_valid = 3'b000;
        req_we    = 3'b000;
        req_lock  = 3'b000;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    logic [25:0] exp_rd [0:2];
    logic [2:0]  exp_oh;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        req_addr  = 48'h0;
        req_wdata = 78'h0;
        exp_rd[0] = 26'h0000100;
        exp_rd[1] = 26'h0000101;
        exp_rd[2] = 26'h0000102;
        do_reset();

        // reset state
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);

        // fetch-only reads of addresses 0,1,2 on consecutive cycles
        for (int a = 0; a < 3; a++) begin
            set_req(0, 1'b1, 1'b0, 1'b0, 16'(a), 26'h0);
            #1;
            check("fetch_ready", 32'(req_ready), 32'h1);
            check("fetch_mem_addr", 32'(mem_addr), 32'(a));
            cyc();
            check("fetch_rsp_valid", 32'(rsp_valid), 32'h1);
            check("fetch_rsp_rdata", 32'(rsp_rdata), 32'(exp_rd[a]));
        end
        idle_all();
        #1;
        check("idle_mem_en", 32'(mem_en), 32'h0);
        check("idle_ready", 32'(req_ready), 32'h0);
        cyc();

        // all three valid: grant order 0,1,2,0,1,2 with responses one cycle later
        do_reset();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0000, 26'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0001, 26'h0);
        set_req(2, 1'b1, 1'b0, 1'b0, 16'h0002, 26'h0);
        for (int k = 0; k < 6; k++) begin
            exp_oh = 3'b001 << (k % 3);
            #1;
            check("rr_ready", 32'(req_ready), 32'(exp_oh));
            cyc();
            check("rr_rsp_valid", 32'(rsp_valid), 32'(exp_oh));
            check("rr_rsp_rdata", 32'(rsp_rdata), 32'(exp_rd[k % 3]));
        end
        idle_all();

        // write by req1 then read-after-write by req0
        set_req(1, 1'b1, 1'b1, 1'b0, 16'h0040, 26'h0000155);
        #1;
        check("wr_ready", 32'(req_ready), 32'h2);
        check("wr_mem_we", 32'(mem_we), 32'h1);
        check("wr_mem_addr", 32'(mem_addr), 32'h40);
        check("wr_mem_wdata", 32'(mem_wdata), 32'h155);
        cyc();
        check("wr_rsp_valid", 32'(rsp_valid), 32'h2);
        check("wr_rsp_rdata", 32'(rsp_rdata), 32'h0);
        idle_all();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0040, 26'h0);
        #1;
        check("raw_ready", 32'(req_ready), 32'h1);
        cyc();
        check("raw_rsp_valid", 32'(rsp_valid), 32'h1);
        check("raw_rsp_rdata", 32'(rsp_rdata), 32'h155);
        idle_all();

        // req2 locks, idles with req0/req1 waiting, then releases with a write
        set_req(2, 1'b1, 1'b0, 1'b1, 16'h0010, 26'h0);
        #1;
        check("lock_ready", 32'(req_ready), 32'h4);
        cyc();
        check("lock_rsp_valid", 32'(rsp_valid), 32'h4);
        check("lock_rsp_rdata", 32'(rsp_rdata), 32'h3AB);
        req_valid[2] = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0000, 26'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0001, 26'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("locked_ready", 32'(req_ready), 32'h0);
            check("locked_mem_en", 32'(mem_en), 32'h0);
            cyc();
            check("locked_rsp_valid", 32'(rsp_valid), 32'h0);
        end
        set_req(2, 1'b1, 1'b1, 1'b0, 16'h0010, 26'h00002AA);
        #1;
        check("unlock_ready", 32'(req_ready), 32'h4);
        cyc();
        check("unlock_rsp_valid", 32'(rsp_valid), 32'h4);
        check("unlock_rsp_rdata", 32'(rsp_rdata), 32'h0);
        req_valid[2] = 1'b0;
        #1;
        check("after_unlock_ready", 32'(req_ready), 32'h1);
        cyc();
        check("after_unlock_rsp", 32'(rsp_valid), 32'h1);
        check("after_unlock_rdata", 32'(rsp_rdata), 32'h100);
        idle_all();

        // req1 takes a lock with a read, then reset arrives the next cycle
        set_req(1, 1'b1, 1'b0, 1'b1, 16'h0001, 26'h0);
        #1;
        check("prerst_ready", 32'(req_ready), 32'h2);
        cyc();
        idle_all();
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h0002, 26'h0);
        set_req(2, 1'b1, 1'b0, 1'b0, 16'h0001, 26'h0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check("postrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("postrst_ready", 32'(req_ready), 32'h1);
        cyc();
        check("postrst_rsp", 32'(rsp_valid), 32'h1);
        check("postrst_rdata", 32'(rsp_rdata), 32'h102);
        idle_all();

`ifdef CALCU16_ARB_LOCK_TIMEOUT_EN
        // owner idles LOCK_TMO cycles: forced release and a single lock_broken pulse
        do_reset();
        set_req(0, 1'b1, 1'b0, 1'b1, 16'h0000, 26'h0);
        #1;
        check("tmo_lock_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h0001, 26'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("tmo_wait_ready", 32'(req_ready), 32'h0);
            check("tmo_wait_broken", 32'(lock_broken), 32'h0);
            cyc();
        end
        cyc();
        check("tmo_broken", 32'(lock_broken), 32'h1);
        check("tmo_ready", 32'(req_ready), 32'h2);
        cyc();
        check("tmo_broken_clear", 32'(lock_broken), 32'h0);
        check("tmo_rsp_valid", 32'(rsp_valid), 32'h2);
        idle_all();
`endif

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/calcu16_mem_arbiter.md
Name: calcu16_mem_arbiter

Overview:
Shares the single 64K x 26-bit unified Calcu-16 memory among NUM_REQ requesters: 0 = instruction fetch, 1 = load/store data, 2 = program loader/debug.
- Grants at most one access per cycle, using round-robin priority and an optional bus lock for read-modify-write sequences.
- Returns read data one cycle after grant, tagged to the granted requester.
- Sits between the CPU core/loader and the memory array. The core stalls on req_ready low.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_W, 16, memory address width
DATA_W, 26, memory word width (16-bit register stores are zero-extended by the requester)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester access request
req_ready  out  NUM_REQ  grant this cycle (one-hot or zero)
req_we  in  NUM_REQ  1 = write, 0 = read
req_lock  in  NUM_REQ  keep the grant with this requester after this access
req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data
rsp_valid  out  NUM_REQ  one-hot response strobe (read data or write ack)
rsp_rdata  out  DATA_W  read data, shared by all requesters
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. rr_ptr=NUM_REQ-1, so requester 0 has first priority. State=OPEN, owner=0.
- Handshake: the transfer completes in the cycle where req_valid[i] & req_ready[i]. Until then the requester holds we/lock/addr/wdata stable. req_ready is combinational from req_valid, state and rr_ptr, with no path from the mem_* inputs.
- Memory outputs are combinational from the winning requester: mem_en=|grant, plus that requester's we/addr/wdata. All are zero when there is no grant.
- OPEN state:
  - The grant goes to the first valid requester scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - On a grant, rr_ptr becomes the winner.
  - If the winner has req_lock=1, the next state is LOCKED with owner=winner.
- LOCKED state:
  - Only the owner can be granted; all other requesters see req_ready=0.
  - A granted owner access with req_lock=0 returns the state to OPEN.
  - rr_ptr is not updated while LOCKED.
  - An owner with req_valid=0 keeps LOCKED. There is no timeout in the base design.
- Response, latency 1: the registered tag (rsp_id, rsp_pend) captures the grant.
  - Next cycle, rsp_valid[rsp_id]=1.
  - For reads, rsp_rdata=mem_rdata. For writes, rsp_rdata=0.
  - Back-to-back grants produce back-to-back responses at full throughput, one per cycle.
- Simultaneous requests: exactly one grant. The losers hold and are served in round-robin order. No requester waits more than NUM_REQ-1 grants while OPEN.
- Reset mid-operation: a pending response is dropped, with rsp_valid=0 in the cycle after rst. The lock is released.
- Read-after-write to the same address in consecutive grants returns the new data, because the memory write completes at the grant edge.

Optional Feature:
CALCU16_ARB_LOCK_TIMEOUT_EN:
- When defined, adds parameter LOCK_TMO (default 16) and an 8-bit idle counter in LOCKED.
  - The counter clears on each owner grant and increments on each cycle the owner has req_valid=0.
  - When it reaches LOCK_TMO, the lock is forcibly released (state=OPEN) and the 1-cycle output lock_broken pulses.
- When undefined, the counter, parameter and lock_broken port are absent. A lock persists until the owner releases it.

Decomposition:
- Package calcu16_mem_pkg holds:
  - ADDR_W and DATA_W constants;
  - requester-ID localparams REQ_FETCH=0, REQ_DATA=1, REQ_LOADER=2;
  - the arbiter state enum {OPEN, LOCKED}.
- One sub-module, calcu16_rr_pick: combinational round-robin picker taking valid and ptr, producing a one-hot grant. It is reused for the lock-masked case by ANDing valid with the owner one-hot.

Test Plan:
- Reset, then fetch-only reads of addrs 0,1,2: grants on consecutive cycles; rsp_valid[0] one cycle after each grant with mem contents; mem_en=0 when idle.
- All three requesters valid continuously after reset: grant order 0,1,2,0,1,2. Each req_ready is high exactly once per 3 cycles.
- Req1 writes 0x155 to addr 0x0040, then req0 reads 0x0040 the next cycle: rsp_valid[1] with rdata 0, then rsp_valid[0] with rdata 0x0000155.
- Req2 reads 0x10 with lock=1, idles 3 cycles while req0/req1 stay valid, then writes 0x10 with lock=0: req0/req1 see no grant until after the write. The next grant goes to req0.
- Assert rst in the cycle after a read grant: rsp_valid stays 0 the next cycle; state OPEN; the next grant goes to requester 0.
- CALCU16_ARB_LOCK_TIMEOUT_EN with LOCK_TMO=4: owner locks, then idles 4 cycles; lock_broken pulses once and another waiting requester is granted the next cycle.
